// File: rtl/operand_fetch.sv
// Operand fetch sequencer: accepts instructions, issues a two-register read to
// the register stack and hands opcode/dst/operands to execute; also arbitrates writebacks.
module operand_fetch #(
    parameter int WORD_SIZE = 16,
    parameter int NIB_SIZE  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [WORD_SIZE-1:0] instr,
    input  logic                 wb_valid,
    output logic                 wb_ready,
    input  logic [NIB_SIZE-1:0]  wb_num,
    input  logic [WORD_SIZE-1:0] wb_val,
    output logic [NIB_SIZE-1:0]  rs_num1,
    output logic [NIB_SIZE-1:0]  rs_num2,
    output logic [NIB_SIZE-1:0]  rs_setnum,
    output logic [WORD_SIZE-1:0] rs_setval,
    output logic                 rs_get_enable,
    output logic                 rs_set_enable,
    input  logic [WORD_SIZE-1:0] rs_out1,
    input  logic [WORD_SIZE-1:0] rs_out2,
    output logic                 op_valid,
    input  logic                 op_ready,
    output logic [NIB_SIZE-1:0]  op_opcode,
    output logic [NIB_SIZE-1:0]  op_dst,
    output logic [WORD_SIZE-1:0] op_a,
    output logic [WORD_SIZE-1:0] op_b
);

    typedef enum logic [1:0] {IDLE, READ, WAIT, HOLD} state_t;

    state_t               state_q, state_d;
    logic [NIB_SIZE-1:0]  opc_q, opc_d, dst_q, dst_d;
    logic [NIB_SIZE-1:0]  src1_q, src1_d, src2_q, src2_d;
    logic                 op_valid_q, op_valid_d;
    logic [NIB_SIZE-1:0]  op_opcode_q, op_opcode_d, op_dst_q, op_dst_d;
    logic [WORD_SIZE-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic                 accept;

    // The read port is busy only in READ, so writes never collide with a read.
    assign wb_ready      = !reset && (state_q != READ);
    assign rs_set_enable = wb_valid && wb_ready;
    assign rs_setnum     = wb_num;
    assign rs_setval     = wb_val;
    assign rs_get_enable = !reset && (state_q == READ);
    assign rs_num1       = src1_q;
    assign rs_num2       = src2_q;

    assign op_valid  = op_valid_q;
    assign op_opcode = op_opcode_q;
    assign op_dst    = op_dst_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;

    always_comb begin
        state_d     = state_q;
        opc_d       = opc_q;
        dst_d       = dst_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        op_valid_d  = op_valid_q;
        op_opcode_d = op_opcode_q;
        op_dst_d    = op_dst_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        instr_ready = 1'b0;

        // Pending writeback wins over a new instruction.
        if (!reset) begin
            case (state_q)
                IDLE:    instr_ready = !wb_valid;
                HOLD:    instr_ready = op_ready && !wb_valid;
                default: instr_ready = 1'b0;
            endcase
        end
        accept = instr_valid && instr_ready;

        if (accept) begin
            opc_d  = instr[WORD_SIZE-1 -: NIB_SIZE];
            dst_d  = instr[WORD_SIZE-NIB_SIZE-1 -: NIB_SIZE];
            src1_d = instr[2*NIB_SIZE-1 -: NIB_SIZE];
            src2_d = instr[NIB_SIZE-1:0];
        end

        case (state_q)
            IDLE: if (accept) state_d = READ;
            READ: state_d = WAIT;
            WAIT: begin
                op_a_d      = rs_out1;
                op_b_d      = rs_out2;
                op_opcode_d = opc_q;
                op_dst_d    = dst_q;
                op_valid_d  = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (op_ready) begin
                    op_valid_d = 1'b0;
                    state_d    = accept ? READ : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            opc_q       <= '0;
            dst_q       <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            op_valid_q  <= 1'b0;
            op_opcode_q <= '0;
            op_dst_q    <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
        end else begin
            state_q     <= state_d;
            opc_q       <= opc_d;
            dst_q       <= dst_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            op_valid_q  <= op_valid_d;
            op_opcode_q <= op_opcode_d;
            op_dst_q    <= op_dst_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: behavioural register stack, directed scenarios and
// randomized traffic scored against a snapshot-at-accept operand model.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0, instr_ready;
    logic [15:0] instr = '0;
    logic        wb_valid = 1'b0, wb_ready;
    logic [3:0]  wb_num = '0;
    logic [15:0] wb_val = '0;
    logic [3:0]  rs_num1, rs_num2, rs_setnum;
    logic [15:0] rs_setval;
    logic        rs_get_enable, rs_set_enable;
    logic [15:0] rs_out1 = '0, rs_out2 = '0;
    logic        op_valid, op_ready = 1'b0;
    logic [3:0]  op_opcode, op_dst;
    logic [15:0] op_a, op_b;

    int checks = 0;
    int errors = 0;

    operand_fetch #(.WORD_SIZE(16), .NIB_SIZE(4)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_num(wb_num), .wb_val(wb_val),
        .rs_num1(rs_num1), .rs_num2(rs_num2), .rs_setnum(rs_setnum), .rs_setval(rs_setval),
        .rs_get_enable(rs_get_enable), .rs_set_enable(rs_set_enable),
        .rs_out1(rs_out1), .rs_out2(rs_out2),
        .op_valid(op_valid), .op_ready(op_ready), .op_opcode(op_opcode), .op_dst(op_dst),
        .op_a(op_a), .op_b(op_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Register stack: powers up with reg i = i, registers outputs on get.
    logic [15:0] rf [16];
    always @(posedge clk) begin
        if (rs_set_enable) rf[rs_setnum] = rs_setval;
        if (rs_get_enable) begin
            rs_out1 <= rf[rs_num1];
            rs_out2 <= rf[rs_num2];
        end
    end

    // Reference model: operands are the register values as of the accept edge,
    // since nothing can be written between accept and the read.
    logic [15:0] shadow [16];
    logic [39:0] exp_q[$];
    int          acc_q[$];
    int          hs_q[$];
    int          cyc = 0;
    bit          seen = 0, stall = 0;
    logic [39:0] stall_snap;

    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            acc_q.delete();
            seen  = 0;
            stall = 0;
        end else begin
            if (stall) begin
                chk("stall_valid", op_valid, 1);
                chk("stall_bundle", {op_opcode, op_dst, op_a, op_b}, stall_snap);
            end
            stall      = op_valid && !op_ready;
            stall_snap = {op_opcode, op_dst, op_a, op_b};
            if (op_valid && !seen) begin
                seen = 1;
                chk("bundle_pending", exp_q.size() != 0, 1);
                // accept edge k raises op_valid at edge k+2, first sampled at k+3
                if (acc_q.size() != 0) chk("latency", cyc - acc_q[0], 3);
            end
            if (op_valid && op_ready) begin
                seen = 0;
                hs_q.push_back(cyc);
                if (exp_q.size() != 0) begin
                    chk("bundle", {op_opcode, op_dst, op_a, op_b}, exp_q[0]);
                    void'(exp_q.pop_front());
                    void'(acc_q.pop_front());
                end
            end
            if (wb_valid && wb_ready) shadow[wb_num] = wb_val;
            if (instr_valid && instr_ready) begin
                exp_q.push_back({instr[15:12], instr[11:8], shadow[instr[7:4]], shadow[instr[3:0]]});
                acc_q.push_back(cyc);
            end
        end
        cyc++;
    end

    always @(negedge clk) chk("get_set_excl", rs_get_enable && rs_set_enable, 0);

    task automatic send_instr(input logic [15:0] w);
        bit done = 0;
        instr       = w;
        instr_valid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (instr_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        instr_valid = 1'b0;
        if (!done) chk("instr_timeout", 0, 1);
    endtask

    task automatic wait_valid();
        bit done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (op_valid) done = 1;
        end
        if (!done) chk("valid_timeout", 0, 1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [39:0] snap;

    initial begin
        for (int i = 0; i < 16; i++) begin
            rf[i]     = 16'(i);
            shadow[i] = 16'(i);
        end
        // Reset: handshakes and enables must be low even with requests offered.
        instr_valid = 1'b1;
        instr       = 16'h1345;
        wb_valid    = 1'b1;
        @(negedge clk);
        chk("rst_instr_ready", instr_ready, 0);
        chk("rst_wb_ready", wb_ready, 0);
        chk("rst_enables", {rs_get_enable, rs_set_enable}, 0);
        chk("rst_op", {op_valid, op_opcode, op_dst, op_a, op_b}, 0);
        chk("rst_nums", {rs_num1, rs_num2}, 0);
        tick();
        instr_valid = 1'b0;
        wb_valid    = 1'b0;
        reset       = 1'b0;
        op_ready    = 1'b1;
        tick();

        // Test 1: basic read and latency.
        send_instr(16'h1345);
        @(negedge clk);
        chk("t1_get", rs_get_enable, 1);
        chk("t1_nums", {rs_num1, rs_num2}, {4'd4, 4'd5});
        @(negedge clk);
        chk("t1_get_once", rs_get_enable, 0);
        chk("t1_not_yet", op_valid, 0);
        @(negedge clk);
        chk("t1_bundle", {op_valid, op_opcode, op_dst, op_a, op_b}, {1'b1, 4'd1, 4'd3, 16'h0004, 16'h0005});
        tick();

        // Test 2: writeback beats an instruction in IDLE.
        wb_valid = 1'b1; wb_num = 4'd4; wb_val = 16'hBEEF;
        instr_valid = 1'b1; instr = 16'h2745;
        @(negedge clk);
        chk("t2_instr_blocked", instr_ready, 0);
        chk("t2_wb_taken", {wb_ready, rs_set_enable}, 2'b11);
        tick();
        wb_valid = 1'b0;
        @(negedge clk);
        chk("t2_instr_ready", instr_ready, 1);
        tick();
        instr_valid = 1'b0;
        wait_valid();
        chk("t2_ops", {op_a, op_b}, {16'hBEEF, 16'h0005});
        tick();

        // Test 3: writeback stalled during READ, accepted next cycle.
        send_instr(16'h3712);
        wb_valid = 1'b1; wb_num = 4'd7; wb_val = 16'h1234;
        @(negedge clk);
        chk("t3_read_wb_ready", {rs_get_enable, wb_ready, rs_set_enable}, 3'b100);
        tick();
        @(negedge clk);
        chk("t3_wb_next", {wb_ready, rs_set_enable}, 2'b11);
        tick();
        wb_valid = 1'b0;
        wait_valid();
        tick();

        // Test 4: stall in HOLD, then back-to-back handoff.
        op_ready = 1'b0;
        send_instr(16'h4012);
        wait_valid();
        snap        = {op_opcode, op_dst, op_a, op_b};
        chk("t4_ops", {op_a, op_b}, {16'h0001, 16'h0002});
        instr_valid = 1'b1;
        instr       = 16'h3066;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold", {op_valid, op_opcode, op_dst, op_a, op_b}, {1'b1, snap});
            chk("t4_no_ready", instr_ready, 0);
        end
        tick();
        op_ready = 1'b1;
        @(negedge clk);
        chk("t4_ready", instr_ready, 1);
        tick();
        instr_valid = 1'b0;
        @(negedge clk);
        chk("t4_read", {op_valid, rs_get_enable, rs_num1, rs_num2}, {1'b0, 1'b1, 4'd6, 4'd6});
        @(negedge clk);
        chk("t4_wait", op_valid, 0);
        @(negedge clk);
        chk("t4_bundle", {op_valid, op_opcode, op_dst, op_a, op_b}, {1'b1, 4'd3, 4'd0, 16'h0006, 16'h0006});
        tick();

        // Test 5: reset in WAIT drops the instruction.
        send_instr(16'h5089);
        tick();
        reset = 1'b1;
        #1;
        chk("t5_rst_now", {op_valid, instr_ready, rs_get_enable}, 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t5_idle", {instr_ready, rs_num1, rs_num2}, {1'b1, 8'h00});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_no_bundle", op_valid, 0);
        end
        tick();
        send_instr(16'h1345);
        wait_valid();
        chk("t5_again", {op_opcode, op_dst, op_a, op_b}, {4'd1, 4'd3, 16'hBEEF, 16'h0005});
        tick();

        // Test 6: four-instruction stream, write to src1 of the third in between.
        send_instr(16'h6123);
        send_instr(16'h7245);
        tick();
        wb_valid = 1'b1; wb_num = 4'd8; wb_val = 16'hCAFE;
        @(negedge clk);
        chk("t6_wb_in_wait", wb_ready, 1);
        tick();
        wb_valid = 1'b0;
        send_instr(16'h8389);
        send_instr(16'h9A01);
        repeat (4) tick();
        if (hs_q.size() >= 4) begin
            for (int i = 0; i < 3; i++)
                chk("t6_gap", hs_q[hs_q.size()-1-i] - hs_q[hs_q.size()-2-i], 3);
        end else begin
            chk("t6_handoffs", hs_q.size(), 4);
        end

        // Randomized traffic scored by the model.
        for (int i = 0; i < 500; i++) begin
            reset       = ($urandom_range(0, 149) == 0);
            instr_valid = $urandom_range(0, 1) == 1;
            instr       = 16'($urandom);
            wb_valid    = ($urandom_range(0, 3) == 0);
            wb_num      = 4'($urandom);
            wb_val      = 16'($urandom);
            op_ready    = ($urandom_range(0, 2) != 0);
            tick();
        end
        reset       = 1'b0;
        instr_valid = 1'b0;
        wb_valid    = 1'b0;
        op_ready    = 1'b1;
        repeat (6) tick();
        chk("drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1);
    end

endmodule
